// File: rtl/dport_unstuff.sv
// DisplayPort main-link deframer: strips BS/BE/FS/FE/SS/SE framing and fill from 1- or 2-lane
// symbol words, rebuilds 24bpp pixel pairs, and captures VB-ID and MSA timing fields.
//   state    | meaning
//   S_BLANK  | between lines; waits for BE (line start), SS SS (MSA) or BS (VB-ID)
//   S_ACTIVE | pixel data feeds the assemblers
//   S_FILL   | stuffing between FS and FE; data discarded, word timeout running
//   S_VBID   | after BS; next data byte is the VB-ID
//   S_MSA    | counting lane-0 MSA bytes until SE
`timescale 1ns/1ps
module dport_unstuff #(
  parameter int FILL_TIMEOUT = 64
) (
  input  logic        dpclk,
  input  logic        resetn,
  input  logic        twolane,
  input  logic [15:0] dpdat0,
  input  logic [15:0] dpdat1,
  input  logic [1:0]  dpisk0,
  input  logic [1:0]  dpisk1,
  output logic        px_valid,
  output logic [47:0] px_data,
  output logic        px_sol,
  output logic        px_eol,
  output logic        px_sof,
  output logic        vblank,
  output logic [7:0]  vbid,
  output logic        msa_valid,
  output logic [15:0] htot,
  output logic [15:0] vtot,
  output logic [15:0] hact,
  output logic [15:0] vact,
  output logic        sym_err
);
  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_BE = 8'hFB;
  localparam logic [7:0] K_FS = 8'hFE;
  localparam logic [7:0] K_FE = 8'hF7;
  localparam logic [7:0] K_SS = 8'h5C;
  localparam logic [7:0] K_SE = 8'hFD;
  localparam logic [6:0] FILL_LOAD = 7'(FILL_TIMEOUT);

  typedef enum logic [2:0] {S_BLANK, S_ACTIVE, S_FILL, S_VBID, S_MSA} state_t;

  state_t      state_q, state_n;
  logic        ss_q, ss_n, ss_prev;
  logic [2:0]  cnt_q, cnt_n;
  logic [47:0] pair_q, pair_n;
  logic        sol_arm_q, sol_arm_n, sof_arm_q, sof_arm_n;
  logic [6:0]  fill_cnt_q, fill_cnt_n;
  logic        fill_loaded;
  logic [5:0]  idx_q, idx_n;
  logic [15:0] sh_htot_q, sh_htot_n, sh_vtot_q, sh_vtot_n;
  logic [15:0] sh_hact_q, sh_hact_n, sh_vact_q, sh_vact_n;
  logic [7:0]  vbid_n;
  logic        emit, e_sol, e_eol, e_sof, err, msa_done;
  logic [47:0] e_data;
  logic [7:0]  b0, b1;
  logic        k;
  logic [5:0]  lo;

  always_comb begin
    state_n     = state_q;
    ss_n        = ss_q;
    ss_prev     = 1'b0;
    cnt_n       = cnt_q;
    pair_n      = pair_q;
    sol_arm_n   = sol_arm_q;
    sof_arm_n   = sof_arm_q;
    fill_cnt_n  = fill_cnt_q;
    fill_loaded = 1'b0;
    idx_n       = idx_q;
    sh_htot_n   = sh_htot_q;
    sh_vtot_n   = sh_vtot_q;
    sh_hact_n   = sh_hact_q;
    sh_vact_n   = sh_vact_q;
    vbid_n      = vbid;
    emit        = 1'b0;
    e_data      = '0;
    e_sol       = 1'b0;
    e_eol       = 1'b0;
    e_sof       = 1'b0;
    msa_done    = 1'b0;
    b0          = '0;
    b1          = '0;
    k           = 1'b0;
    lo          = '0;
    err         = twolane && (dpisk0 != dpisk1);

    // Symbol 0 then symbol 1; each sees the state left by the previous one.
    for (int s = 0; s < 2; s++) begin
      b0      = (s == 1) ? dpdat0[15:8] : dpdat0[7:0];
      b1      = (s == 1) ? dpdat1[15:8] : dpdat1[7:0];
      k       = (s == 1) ? dpisk0[1] : dpisk0[0];
      lo      = {cnt_n, 3'b000};
      ss_prev = ss_n;
      ss_n    = 1'b0;
      if (state_n == S_VBID && k) begin
        err     = 1'b1;
        state_n = S_BLANK;
      end
      case (state_n)
        S_BLANK: begin
          if (k) begin
            if (b0 == K_BE) begin
              cnt_n     = '0;
              pair_n    = '0;
              sol_arm_n = 1'b1;
              state_n   = S_ACTIVE;
            end else if (b0 == K_SS) begin
              if (ss_prev) begin
                state_n = S_MSA;
                idx_n   = '0;
              end else begin
                ss_n = 1'b1;
              end
            end else if (b0 == K_BS) begin
              state_n = S_VBID;
            end
          end
        end
        S_ACTIVE, S_FILL: begin
          if (!k) begin
            if (state_n == S_ACTIVE) begin
              pair_n[lo +: 8] = b0;
              if (twolane) pair_n[lo + 6'd24 +: 8] = b1;
              cnt_n = cnt_n + 3'd1;
              if (cnt_n == (twolane ? 3'd3 : 3'd6)) begin
                emit      = 1'b1;
                e_data    = pair_n;
                e_sol     = sol_arm_n;
                e_sof     = sof_arm_n;
                sol_arm_n = 1'b0;
                sof_arm_n = 1'b0;
                pair_n    = '0;
                cnt_n     = '0;
              end
            end
          end else if (b0 == K_BS) begin
            // eol marks the pair that completes in the same word as BS
            if (cnt_n == 3'd0) begin
              if (emit) e_eol = 1'b1;
            end else begin
              if (!twolane && cnt_n >= 3'd3) begin
                emit      = 1'b1;
                e_data    = {24'h0, pair_n[23:0]};
                e_sol     = sol_arm_n;
                e_sof     = sof_arm_n;
                e_eol     = 1'b1;
                sol_arm_n = 1'b0;
                sof_arm_n = 1'b0;
              end
              if (twolane || cnt_n != 3'd3) err = 1'b1;
              cnt_n  = '0;
              pair_n = '0;
            end
            state_n = S_VBID;
          end else if (state_n == S_ACTIVE && b0 == K_FS) begin
            state_n     = S_FILL;
            fill_cnt_n  = FILL_LOAD;
            fill_loaded = 1'b1;
          end else if (state_n == S_FILL && b0 == K_FE) begin
            state_n = S_ACTIVE;
          end else begin
            err = 1'b1;
          end
        end
        S_VBID: begin
          if (vbid_n[0] && !b0[0]) sof_arm_n = 1'b1;
          vbid_n  = b0;
          state_n = S_BLANK;
        end
        S_MSA: begin
          if (!k) begin
            if (idx_n > 6'd40) begin
              err     = 1'b1;
              state_n = S_BLANK;
            end else begin
              case (idx_n)
                6'd3:    sh_htot_n[15:8] = b0;
                6'd4:    sh_htot_n[7:0]  = b0;
                6'd5:    sh_vtot_n[15:8] = b0;
                6'd6:    sh_vtot_n[7:0]  = b0;
                default: ;
              endcase
              case (idx_n - (twolane ? 6'd12 : 6'd21))
                6'd0:    sh_hact_n[15:8] = b0;
                6'd1:    sh_hact_n[7:0]  = b0;
                6'd2:    sh_vact_n[15:8] = b0;
                6'd3:    sh_vact_n[7:0]  = b0;
                default: ;
              endcase
              if (idx_n != 6'd63) idx_n = idx_n + 6'd1;
            end
          end else if (b0 == K_SE) begin
            if (idx_n >= (twolane ? 6'd16 : 6'd25)) msa_done = 1'b1;
            state_n = S_BLANK;
          end else if (b0 != K_SS) begin
            err = 1'b1;
          end
        end
        default: state_n = S_BLANK;
      endcase
    end

    if (state_q == S_FILL && state_n == S_FILL && !fill_loaded) begin
      if (fill_cnt_q == 7'd0) begin
        err     = 1'b1;
        state_n = S_BLANK;
      end else begin
        fill_cnt_n = fill_cnt_q - 7'd1;
      end
    end
  end

  always_ff @(posedge dpclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_BLANK;
      ss_q       <= 1'b0;
      cnt_q      <= '0;
      pair_q     <= '0;
      sol_arm_q  <= 1'b0;
      sof_arm_q  <= 1'b0;
      fill_cnt_q <= '0;
      idx_q      <= '0;
      sh_htot_q  <= '0;
      sh_vtot_q  <= '0;
      sh_hact_q  <= '0;
      sh_vact_q  <= '0;
      px_valid   <= 1'b0;
      px_data    <= '0;
      px_sol     <= 1'b0;
      px_eol     <= 1'b0;
      px_sof     <= 1'b0;
      vbid       <= '0;
      msa_valid  <= 1'b0;
      htot       <= '0;
      vtot       <= '0;
      hact       <= '0;
      vact       <= '0;
      sym_err    <= 1'b0;
    end else begin
      state_q    <= state_n;
      ss_q       <= ss_n;
      cnt_q      <= cnt_n;
      pair_q     <= pair_n;
      sol_arm_q  <= sol_arm_n;
      sof_arm_q  <= sof_arm_n;
      fill_cnt_q <= fill_cnt_n;
      idx_q      <= idx_n;
      sh_htot_q  <= sh_htot_n;
      sh_vtot_q  <= sh_vtot_n;
      sh_hact_q  <= sh_hact_n;
      sh_vact_q  <= sh_vact_n;
      px_valid   <= emit;
      px_data    <= e_data;
      px_sol     <= e_sol;
      px_eol     <= e_eol;
      px_sof     <= e_sof;
      vbid       <= vbid_n;
      msa_valid  <= msa_done;
      sym_err    <= err;
      if (msa_done) begin
        htot <= sh_htot_n;
        vtot <= sh_vtot_n;
        hact <= sh_hact_n;
        vact <= sh_vact_n;
      end
    end
  end

  assign vblank = vbid[0];
endmodule

// File: tb/tb_dport_unstuff.sv
// Scoreboard bench for dport_unstuff: directed symbol streams push hand-computed pixel pairs and
// MSA fields into queues; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_dport_unstuff;
  logic        dpclk = 1'b0;
  logic        resetn = 1'b0;
  logic        twolane = 1'b0;
  logic [15:0] dpdat0 = '0, dpdat1 = '0;
  logic [1:0]  dpisk0 = '0, dpisk1 = '0;
  logic        px_valid, px_sol, px_eol, px_sof, vblank, msa_valid, sym_err;
  logic [47:0] px_data;
  logic [7:0]  vbid;
  logic [15:0] htot, vtot, hact, vact;

  dport_unstuff dut (
    .dpclk(dpclk), .resetn(resetn), .twolane(twolane),
    .dpdat0(dpdat0), .dpdat1(dpdat1), .dpisk0(dpisk0), .dpisk1(dpisk1),
    .px_valid(px_valid), .px_data(px_data), .px_sol(px_sol), .px_eol(px_eol), .px_sof(px_sof),
    .vblank(vblank), .vbid(vbid), .msa_valid(msa_valid),
    .htot(htot), .vtot(vtot), .hact(hact), .vact(vact), .sym_err(sym_err)
  );

  always #5 dpclk = ~dpclk;

  localparam logic [8:0] K_BS = 9'h1BC, K_BE = 9'h1FB, K_FS = 9'h1FE;
  localparam logic [8:0] K_FE = 9'h1F7, K_SS = 9'h15C, K_SE = 9'h1FD;

  typedef struct packed { logic [47:0] data; logic sol; logic eol; logic sof; } px_t;
  typedef struct packed { logic [15:0] htot; logic [15:0] vtot; logic [15:0] hact; logic [15:0] vact; } msa_t;

  px_t        px_q[$];
  msa_t       msa_q[$];
  px_t        exp_px;
  msa_t       exp_msa;
  logic [8:0] sq[$];
  logic [7:0] mb[25];
  int n_vec = 0, n_err = 0, err_seen = 0, exp_err = 0;

  function automatic logic [8:0] D(input logic [7:0] b);
    return {1'b0, b};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_px(input logic [47:0] d, input logic sol, input logic eol, input logic sof);
    px_q.push_back({d, sol, eol, sof});
  endtask

  task automatic word(input logic [15:0] d0, input logic [1:0] k0, input logic [15:0] d1, input logic [1:0] k1);
    @(posedge dpclk);
    #1;
    dpdat0 = d0; dpisk0 = k0; dpdat1 = d1; dpisk1 = k1;
  endtask

  task automatic tx1(input logic [8:0] s0, input logic [8:0] s1);
    word({s1[7:0], s0[7:0]}, {s1[8], s0[8]}, 16'h0, 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) word(16'h0, 2'b00, 16'h0, 2'b00);
  endtask

  task automatic send_q();
    logic [8:0] s0, s1;
    while (sq.size() > 0) begin
      s0 = sq.pop_front();
      s1 = (sq.size() > 0) ? sq.pop_front() : D(8'h00);
      tx1(s0, s1);
    end
  endtask

  always @(negedge dpclk) begin
    if (sym_err) err_seen++;
    if (px_valid) begin
      if (px_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL px_unexpected: got px_data %0h, expected no pixel", px_data);
      end else begin
        exp_px = px_q.pop_front();
        check("px_data", {16'h0, px_data}, {16'h0, exp_px.data});
        check("px_sol", {63'h0, px_sol}, {63'h0, exp_px.sol});
        check("px_eol", {63'h0, px_eol}, {63'h0, exp_px.eol});
        check("px_sof", {63'h0, px_sof}, {63'h0, exp_px.sof});
      end
    end
    if (msa_valid) begin
      if (msa_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL msa_unexpected: got msa_valid 1, expected 0");
      end else begin
        exp_msa = msa_q.pop_front();
        check("htot", {48'h0, htot}, {48'h0, exp_msa.htot});
        check("vtot", {48'h0, vtot}, {48'h0, exp_msa.vtot});
        check("hact", {48'h0, hact}, {48'h0, exp_msa.hact});
        check("vact", {48'h0, vact}, {48'h0, exp_msa.vact});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_px_valid", {63'h0, px_valid}, 64'h0);
    check("rst_px_data", {16'h0, px_data}, 64'h0);
    check("rst_sym_err", {63'h0, sym_err}, 64'h0);
    check("rst_vbid", {56'h0, vbid}, 64'h0);
    check("rst_msa", {htot, vtot, hact, vact}, 64'h0);
    @(posedge dpclk); #2 resetn = 1'b1;
    idle(2);

    // one-lane line, BS shares the word with the last byte
    push_px(48'h060504_030201, 1'b1, 1'b1, 1'b0);
    tx1(K_BE, D(8'h01)); tx1(D(8'h02), D(8'h03)); tx1(D(8'h04), D(8'h05));
    tx1(D(8'h06), K_BS); tx1(D(8'h00), D(8'h00));
    idle(3);
    check("t1_vbid", {56'h0, vbid}, 64'h00);

    // fill region between FS and FE is dropped
    push_px(48'hb3b2b1_a3a2a1, 1'b1, 1'b1, 1'b0);
    tx1(K_BE, D(8'ha1)); tx1(D(8'ha2), D(8'ha3)); tx1(K_FS, D(8'hee));
    repeat (10) tx1(D(8'hee), D(8'hee));
    tx1(D(8'hee), K_FE); tx1(D(8'hb1), D(8'hb2)); tx1(D(8'hb3), K_BS); tx1(D(8'h07), D(8'h00));
    idle(3);
    check("t2_vbid", {56'h0, vbid}, 64'h07);
    check("t2_vblank", {63'h0, vblank}, 64'h1);
    check("t2_sym_err_cnt", err_seen, exp_err);

    // two-lane: pair = {lane1 pixel, lane0 pixel}
    twolane = 1'b1;
    push_px(48'h232221_131211, 1'b1, 1'b1, 1'b0);
    word({8'hFB, 8'h00}, 2'b10, {8'hFB, 8'h00}, 2'b10);
    word({8'h12, 8'h11}, 2'b00, {8'h22, 8'h21}, 2'b00);
    word({8'hBC, 8'h13}, 2'b10, {8'hBC, 8'h23}, 2'b10);
    word({8'h09, 8'h09}, 2'b00, {8'h09, 8'h09}, 2'b00);
    idle(2);
    check("t3_vbid", {56'h0, vbid}, 64'h09);
    word(16'h0, 2'b00, 16'h0, 2'b01);
    exp_err++;
    idle(3);
    check("t3_lane_k_mismatch", err_seen, exp_err);
    twolane = 1'b0;

    // one-lane, three pixels, BS in the later byte flushes a lone pixel
    push_px(48'h363534_333231, 1'b1, 1'b0, 1'b0);
    push_px(48'h000000_393837, 1'b0, 1'b1, 1'b0);
    tx1(D(8'h00), K_BE); tx1(D(8'h31), D(8'h32)); tx1(D(8'h33), D(8'h34));
    tx1(D(8'h35), D(8'h36)); tx1(D(8'h37), D(8'h38)); tx1(D(8'h39), K_BS);
    tx1(D(8'h11), D(8'h00));
    idle(3);
    check("t4_sym_err_cnt", err_seen, exp_err);

    // one-lane MSA, then a truncated MSA that must not update the fields
    for (int i = 0; i < 25; i++) mb[i] = 8'ha0 + 8'(i);
    mb[3] = 8'h05; mb[4] = 8'h40; mb[5] = 8'h04; mb[6] = 8'h65;
    mb[21] = 8'h04; mb[22] = 8'h00; mb[23] = 8'h03; mb[24] = 8'h00;
    msa_q.push_back({16'h0540, 16'h0465, 16'h0400, 16'h0300});
    sq.push_back(K_SS); sq.push_back(K_SS);
    for (int i = 0; i < 25; i++) sq.push_back(D(mb[i]));
    sq.push_back(K_SE);
    send_q();
    idle(3);
    sq.push_back(K_SS); sq.push_back(K_SS);
    for (int i = 0; i < 10; i++) sq.push_back(D(8'h77));
    sq.push_back(K_SE);
    send_q();
    idle(3);
    check("t5_htot_kept", {48'h0, htot}, 64'h0540);
    check("t5_hact_kept", {48'h0, hact}, 64'h0400);
    check("t5_sym_err_cnt", err_seen, exp_err);

    // FE inside ACTIVE is a framing error but the line continues
    push_px(48'h464544_434241, 1'b1, 1'b1, 1'b0);
    tx1(D(8'h00), K_BE); tx1(K_FE, D(8'h41)); tx1(D(8'h42), D(8'h43));
    tx1(D(8'h44), D(8'h45)); tx1(D(8'h46), K_BS); tx1(D(8'h13), D(8'h00));
    exp_err++;
    idle(3);
    check("t7_stray_fe", err_seen, exp_err);

    // FILL left open past the timeout
    tx1(K_BE, K_FS);
    repeat (66) tx1(D(8'hee), D(8'hee));
    exp_err++;
    idle(3);
    check("t8_fill_timeout", err_seen, exp_err);
    check("t8_vbid", {56'h0, vbid}, 64'h13);

    // reset mid-line, data before BE ignored, then frame start gives px_sof
    tx1(D(8'h00), K_BE); tx1(D(8'h51), D(8'h52));
    @(posedge dpclk); #2 resetn = 1'b0;
    #1;
    check("t6_async_vbid", {56'h0, vbid}, 64'h0);
    check("t6_async_htot", {48'h0, htot}, 64'h0);
    check("t6_async_vblank", {63'h0, vblank}, 64'h0);
    @(posedge dpclk); #2 resetn = 1'b1;
    tx1(D(8'h53), D(8'h54)); tx1(D(8'h55), D(8'h56)); tx1(D(8'h57), D(8'h58));
    tx1(K_BS, D(8'h01)); tx1(K_BS, D(8'h00));
    push_px(48'h666564_636261, 1'b1, 1'b1, 1'b1);
    tx1(K_BE, D(8'h61)); tx1(D(8'h62), D(8'h63)); tx1(D(8'h64), D(8'h65));
    tx1(D(8'h66), K_BS); tx1(D(8'h02), D(8'h00));
    idle(4);
    check("t6_vbid", {56'h0, vbid}, 64'h02);
    check("px_queue_drained", px_q.size(), 0);
    check("msa_queue_drained", msa_q.size(), 0);
    check("final_sym_err_cnt", err_seen, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
